// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the GPU data-memory channel protocol. Serves NUM_CHANNELS
// read and write request channels against one internal single-port word RAM,
// granting at most one RAM operation per cycle in round-robin order. A host
// port preloads the RAM and always wins over channel traffic.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high
//   mem_read_valid      per-channel read request (level, held until ready seen)
//   mem_read_address    per-channel read word address
//   mem_read_ready      per-channel read response, data valid while high
//   mem_read_data       per-channel read data, held while ready is high
//   mem_write_valid     per-channel write request (level)
//   mem_write_address   per-channel write word address
//   mem_write_data      per-channel write data
//   mem_write_ready     per-channel write acknowledge
//   host_write_en       host preload write strobe (blocks all grants that cycle)
//   host_write_address  host preload address
//   host_write_data     host preload data
//   busy                any request slot not IDLE

`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_mem_responder #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = `DATA_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready,
    input  logic                                   host_write_en,
    input  logic [ADDR_WIDTH-1:0]                  host_write_address,
    input  logic [DATA_WIDTH-1:0]                  host_write_data,
    output logic                                   busy
);

    localparam int NUM_SLOTS  = 2 * NUM_CHANNELS;
    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int CH_W       = (SLOT_W > 1) ? SLOT_W - 1 : 1;
    localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // The last latency stage is the output register itself, so the internal
    // pipe holds READ_LATENCY-1 stages (one dummy stage when latency is 1).
    localparam int PIPE_DEPTH = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2,
        RESPOND  = 2'd3
    } slot_state_t;

    // Addresses beyond the storage read as zero and swallow writes.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    slot_state_t           state_r   [NUM_SLOTS];
    slot_state_t           state_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  slot_valid;
    logic [NUM_SLOTS-1:0]  req;
    logic [NUM_SLOTS-1:0]  kill;
    logic                  busy_nxt;

    logic [SLOT_W-1:0]     rr_r;
    logic                  grant_en;
    logic [SLOT_W-1:0]     grant_idx;
    logic [CH_W-1:0]       grant_ch;
    logic                  grant_is_write;
    int                    arb_idx;
    logic                  arb_hit;

    logic [ADDR_WIDTH-1:0] grant_raddr;
    logic [ADDR_WIDTH-1:0] grant_waddr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  wr_en;
    logic [MEM_AW-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  pipe_v    [PIPE_DEPTH];
    logic [SLOT_W-1:0]     pipe_slot [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_data [PIPE_DEPTH];
    logic                  del_v;
    logic [SLOT_W-1:0]     del_slot;
    logic [DATA_WIDTH-1:0] del_data;

    // Map channel requests onto slots (even = read, odd = write) and find live requests.
    always_comb begin
        slot_valid = '0;
        req        = '0;
        kill       = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            slot_valid[2*c]   = mem_read_valid[c];
            slot_valid[2*c+1] = mem_write_valid[c];
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            req[s]  = (state_r[s] == PENDING) && slot_valid[s] && !host_write_en;
            // An in-flight read whose requester walked away must never be delivered.
            kill[s] = (state_r[s] == INFLIGHT) && !slot_valid[s];
        end
    end

    // Round-robin arbiter: first requesting slot at or above the pointer, wrapping.
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        arb_hit   = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            arb_idx   = int'(rr_r) + k;
            arb_idx   = (arb_idx >= NUM_SLOTS) ? arb_idx - NUM_SLOTS : arb_idx;
            arb_hit   = req[arb_idx] && !grant_en;
            grant_idx = arb_hit ? SLOT_W'(arb_idx) : grant_idx;
            grant_en  = grant_en || arb_hit;
        end
    end

    // Decode the granted slot and perform the RAM read for it.
    always_comb begin
        grant_ch       = CH_W'(grant_idx >> 1);
        grant_is_write = grant_idx[0];
        grant_raddr    = mem_read_address[grant_ch];
        grant_waddr    = mem_write_address[grant_ch];
        if (in_range(grant_raddr)) begin
            rd_data = mem[grant_raddr[MEM_AW-1:0]];
        end else begin
            rd_data = '0;
        end
    end

    // Single RAM write port: host preload has absolute priority over a granted write.
    always_comb begin
        if (host_write_en) begin
            wr_en   = in_range(host_write_address);
            wr_addr = host_write_address[MEM_AW-1:0];
            wr_data = host_write_data;
        end else begin
            wr_en   = grant_en && grant_is_write && in_range(grant_waddr);
            wr_addr = grant_waddr[MEM_AW-1:0];
            wr_data = mem_write_data[grant_ch];
        end
    end

    // RAM storage, not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read result leaving the pipe this cycle.
    always_comb begin
        del_v    = pipe_v[PIPE_DEPTH-1];
        del_slot = pipe_slot[PIPE_DEPTH-1];
        del_data = pipe_data[PIPE_DEPTH-1];
    end

    // Read data pipeline; entries of abandoned reads are dropped as they shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_slot[i] <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_v[0]    <= grant_en && !grant_is_write && (READ_LATENCY > 1);
            pipe_slot[0] <= grant_idx;
            pipe_data[0] <= rd_data;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_v[i]    <= pipe_v[i-1] && !kill[pipe_slot[i-1]];
                pipe_slot[i] <= pipe_slot[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Per-slot next state. Writes complete at their grant edge, so they go
    // straight from PENDING to RESPOND; reads do too only at latency 1.
    always_comb begin
        busy_nxt = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_nxt[s] = state_r[s];
            case (state_r[s])
                IDLE: begin
                    if (slot_valid[s]) begin
                        state_nxt[s] = PENDING;
                    end else begin
                        state_nxt[s] = IDLE;
                    end
                end
                PENDING: begin
                    if (!slot_valid[s]) begin
                        state_nxt[s] = IDLE;
                    end else if (grant_en && (grant_idx == SLOT_W'(s))) begin
                        if ((s % 2 == 1) || (READ_LATENCY == 1)) begin
                            state_nxt[s] = RESPOND;
                        end else begin
                            state_nxt[s] = INFLIGHT;
                        end
                    end else begin
                        state_nxt[s] = PENDING;
                    end
                end
                INFLIGHT: begin
                    if (!slot_valid[s]) begin
                        state_nxt[s] = IDLE;
                    end else if (del_v && (del_slot == SLOT_W'(s))) begin
                        state_nxt[s] = RESPOND;
                    end else begin
                        state_nxt[s] = INFLIGHT;
                    end
                end
                RESPOND: begin
                    if (slot_valid[s]) begin
                        state_nxt[s] = RESPOND;
                    end else begin
                        state_nxt[s] = IDLE;
                    end
                end
                default: begin
                    state_nxt[s] = IDLE;
                end
            endcase
            busy_nxt = busy_nxt || (state_nxt[s] != IDLE);
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_r[s] <= IDLE;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_r[s] <= state_nxt[s];
            end
        end
    end

    // Round-robin pointer moves past the slot just granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_r <= '0;
        end else if (grant_en) begin
            rr_r <= (grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + SLOT_W'(1);
        end
    end

    // Registered responses: ready mirrors the RESPOND state, data loads on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
            busy            <= 1'b0;
        end else begin
            busy <= busy_nxt;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                mem_read_ready[c]  <= (state_nxt[2*c] == RESPOND);
                mem_write_ready[c] <= (state_nxt[2*c+1] == RESPOND);
                if ((state_nxt[2*c] == RESPOND) && (state_r[2*c] != RESPOND)) begin
                    // Coming from PENDING only happens at latency 1 (data straight from RAM).
                    mem_read_data[c] <= (state_r[2*c] == PENDING) ? rd_data : del_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed bench for data_mem_responder: preload, single read timing, full
// 8-channel round-robin sweep, write-then-read ordering, host priority,
// out-of-range access, abandoned read, and mid-operation reset.

module tb_data_mem_responder;

    localparam int NCH = 8;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int MD  = 1024;
    localparam int RL  = 2;

    logic                   clk;
    logic                   reset;
    logic [NCH-1:0]         rv;
    logic [NCH-1:0][AW-1:0] ra;
    logic [NCH-1:0]         rready;
    logic [NCH-1:0][DW-1:0] rdata;
    logic [NCH-1:0]         wv;
    logic [NCH-1:0][AW-1:0] wa;
    logic [NCH-1:0][DW-1:0] wd;
    logic [NCH-1:0]         wready;
    logic                   host_en;
    logic [AW-1:0]          host_addr;
    logic [DW-1:0]          host_data;
    logic                   busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    data_mem_responder #(
        .NUM_CHANNELS (NCH),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (MD),
        .READ_LATENCY (RL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_read_valid     (rv),
        .mem_read_address   (ra),
        .mem_read_ready     (rready),
        .mem_read_data      (rdata),
        .mem_write_valid    (wv),
        .mem_write_address  (wa),
        .mem_write_data     (wd),
        .mem_write_ready    (wready),
        .host_write_en      (host_en),
        .host_write_address (host_addr),
        .host_write_data    (host_data),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_en   = 1'b1;
        host_addr = a;
        host_data = d;
        tick();
        host_en   = 1'b0;
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int n;
        n = 0;
        rv[ch] = 1'b1;
        ra[ch] = a;
        tick();
        while (!rready[ch] && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("rd_ready ch%0d a%0d", ch, a), 64'(rready[ch]), 64'd1);
        check($sformatf("rd_data ch%0d a%0d", ch, a), 64'(rdata[ch]), 64'(exp));
        rv[ch] = 1'b0;
        tick();
        check($sformatf("rd_ready_low ch%0d", ch), 64'(rready[ch]), 64'd0);
    endtask

    task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        wv[ch] = 1'b1;
        wa[ch] = a;
        wd[ch] = d;
        tick();
        while (!wready[ch] && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("wr_ready ch%0d a%0d", ch, a), 64'(wready[ch]), 64'd1);
        wv[ch] = 1'b0;
        tick();
        check($sformatf("wr_ready_low ch%0d", ch), 64'(wready[ch]), 64'd0);
    endtask

    initial begin
        logic [NCH-1:0] exp_mask;

        reset = 1'b1;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        host_en = 1'b0; host_addr = '0; host_data = '0;
        tick();
        tick();
        check("reset rready", 64'(rready), 64'd0);
        check("reset wready", 64'(wready), 64'd0);
        check("reset rdata0", 64'(rdata[0]), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // Preload.
        host_wr(12'd5, 32'hDEADBEEF);
        host_wr(12'd10, 32'h00005555);
        host_wr(12'd20, 32'h20202020);
        host_wr(12'd3, 32'h00003333);
        for (int c = 0; c < NCH; c++) begin
            host_wr(12'(100 + c), 32'hA000 + 32'(c));
        end
        check("host no busy", 64'(busy), 64'd0);

        // Single read, exact timing: cycle 0 request, ready from cycle 3.
        rv[0] = 1'b1;
        ra[0] = 12'd5;
        tick();
        check("t1 c1 ready", 64'(rready[0]), 64'd0);
        check("t1 c1 busy", 64'(busy), 64'd1);
        tick();
        check("t1 c2 ready", 64'(rready[0]), 64'd0);
        tick();
        check("t1 c3 ready", 64'(rready[0]), 64'd1);
        check("t1 c3 data", 64'(rdata[0]), 64'hDEADBEEF);
        tick();
        check("t1 c4 ready held", 64'(rready[0]), 64'd1);
        check("t1 c4 data held", 64'(rdata[0]), 64'hDEADBEEF);
        rv[0] = 1'b0;
        tick();
        check("t1 c5 ready low", 64'(rready[0]), 64'd0);
        check("t1 c5 busy", 64'(busy), 64'd0);

        // All channels read at once from a fresh pointer: ch c ready from cycle 3+c.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ra[c] = 12'(100 + c);
        end
        rv = '1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            exp_mask = '0;
            for (int c = 0; c < NCH; c++) begin
                exp_mask[c] = (t >= 3 + c);
            end
            check($sformatf("t2 c%0d ready mask", t), 64'(rready), 64'(exp_mask));
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("t2 data ch%0d", c), 64'(rdata[c]), 64'hA000 + 64'(c));
        end
        check("t2 busy before drop", 64'(busy), 64'd1);
        rv = '0;
        tick();
        check("t2 ready low", 64'(rready), 64'd0);
        check("t2 busy low", 64'(busy), 64'd0);

        // Pointer sits at 15: ch3 write (slot 7) wins, then ch6 read (slot 12) sees it.
        wv[3] = 1'b1; wa[3] = 12'd10; wd[3] = 32'h00001234;
        rv[6] = 1'b1; ra[6] = 12'd10;
        tick();
        check("t3 c1 wready", 64'(wready[3]), 64'd0);
        tick();
        check("t3 c2 wready", 64'(wready[3]), 64'd1);
        check("t3 c2 rready", 64'(rready[6]), 64'd0);
        tick();
        check("t3 c3 rready", 64'(rready[6]), 64'd0);
        tick();
        check("t3 c4 rready", 64'(rready[6]), 64'd1);
        check("t3 c4 rdata", 64'(rdata[6]), 64'h1234);
        wv[3] = 1'b0;
        rv[6] = 1'b0;
        tick();
        check("t3 ready low", 64'({rready[6], wready[3]}), 64'd0);

        // Host holds the RAM for 4 cycles; grants resume afterwards (slot 2 then 11).
        rv[1] = 1'b1; ra[1] = 12'd20;
        wv[5] = 1'b1; wa[5] = 12'd21; wd[5] = 32'h00000077;
        tick();
        for (int i = 0; i < 4; i++) begin
            host_en   = 1'b1;
            host_addr = 12'(30 + i);
            host_data = 32'(48 + i);
            tick();
        end
        host_en = 1'b0;
        check("t4 c5 no ready", 64'({rready[1], wready[5]}), 64'd0);
        check("t4 c5 busy", 64'(busy), 64'd1);
        tick();
        check("t4 c6 no ready", 64'({rready[1], wready[5]}), 64'd0);
        tick();
        check("t4 c7 both ready", 64'({rready[1], wready[5]}), 64'd3);
        check("t4 c7 rdata", 64'(rdata[1]), 64'h20202020);
        rv[1] = 1'b0;
        wv[5] = 1'b0;
        tick();

        // Read abandoned while in flight: no ready, then a fresh read is clean.
        rv[4] = 1'b1; ra[4] = 12'd5;
        tick();
        tick();
        rv[4] = 1'b0;
        tick();
        check("t5 abandon ready", 64'(rready[4]), 64'd0);
        check("t5 abandon busy", 64'(busy), 64'd0);
        tick();
        tick();
        check("t5 abandon ready later", 64'(rready[4]), 64'd0);
        do_read(4, 12'd3, 32'h00003333);

        // Out-of-range accesses and earlier writes.
        do_write(2, 12'(MD + 3), 32'h00000BAD);
        do_read(2, 12'(MD + 3), 32'h0);
        do_read(0, 12'd3, 32'h00003333);
        do_read(0, 12'd21, 32'h00000077);
        do_read(7, 12'd31, 32'd49);

        // Reset during in-flight reads.
        for (int c = 0; c < 3; c++) begin
            ra[c] = 12'(100 + c);
        end
        rv[2:0] = 3'b111;
        tick();
        tick();
        tick();
        check("t6 busy before reset", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6 reset rready", 64'(rready), 64'd0);
        check("t6 reset busy", 64'(busy), 64'd0);
        check("t6 reset rdata0", 64'(rdata[0]), 64'd0);
        rv = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6 post c%0d rready", i), 64'(rready), 64'd0);
        end
        check("t6 post busy", 64'(busy), 64'd0);
        do_read(0, 12'd5, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
